// File: rtl/burrito_pkg.sv
// Shared definitions for the Burrito instruction bus: word layout, HALT opcode
// and the fetch sequencer states.
package burrito_pkg;

  localparam int INSTR_W = 20;
  localparam int FIELD_W = 5;

  localparam int OP_HI   = 19;
  localparam int OP_LO   = 15;
  localparam int SRCA_HI = 14;
  localparam int SRCA_LO = 10;
  localparam int SRCB_HI = 9;
  localparam int SRCB_LO = 5;
  localparam int DEST_HI = 4;
  localparam int DEST_LO = 0;

  localparam logic [FIELD_W-1:0] OP_HALT = 5'b11111;

  typedef enum logic [2:0] {
    IDLE,
    LEER,
    STALL,
    EMITIR,
    FIN
  } fetch_state_t;

endpackage

// File: rtl/instr_mem.sv
// Program store for the fetch unit: DEPTH x INSTR_W array with synchronous
// write and a registered, enable-gated read port.
module instr_mem
  import burrito_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic               i_re,
  input  logic [AW-1:0]      i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit feeding the Burrito datapath over valid/ready.
// Optional RAW bubble insertion is enabled by defining FETCH_RAW_STALL_EN.
module instr_fetch
  import burrito_pkg::*;
#(
  parameter int                 DEPTH        = 32,
  parameter int                 AW           = 5,
  parameter logic [FIELD_W-1:0] OP_HALT      = burrito_pkg::OP_HALT,
  parameter int                 STALL_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               carga_en,
  input  logic [AW-1:0]      carga_dir,
  input  logic [INSTR_W-1:0] carga_dato,
  input  logic               inicio,
  output logic [INSTR_W-1:0] instruccion,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [AW-1:0]      pc,
  output logic               ocupado,
  output logic               hecho
);

  localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

  fetch_state_t       r_state;
  logic [AW-1:0]      r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic               r_ocupado;
  logic               r_hecho;

  logic [INSTR_W-1:0] w_rdata;
  logic               w_start;
  logic               w_xfer;
  logic               w_last;
  logic               w_halt;
  logic               w_to_fin;
  logic               w_we;
  logic               w_re;
  logic [AW-1:0]      w_raddr;
  logic               w_raw;
  logic               w_stall_done;

  assign w_start  = inicio && (r_state == IDLE || r_state == FIN);
  assign w_xfer   = (r_state == EMITIR) && r_valid && instr_ready;
  assign w_last   = (r_pc == PC_LAST);
  assign w_halt   = (w_rdata[OP_HI:OP_LO] == OP_HALT);
  assign w_to_fin = ((r_state == LEER) && w_halt) || (w_xfer && w_last);
  assign w_we     = carga_en && (r_state == IDLE || r_state == FIN);

  // The read is launched on the edge that enters LEER, so the word for the
  // new pc is already on the RAM output register while LEER decides.
  assign w_re    = w_start || (w_xfer && !w_last);
  assign w_raddr = w_start ? '0 : r_pc + AW'(1);

  instr_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (carga_dir),
    .i_wdata (carga_dato),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

`ifdef FETCH_RAW_STALL_EN
  localparam int SCW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_CYCLES - 1);

  logic [FIELD_W-1:0] r_dest;
  logic               r_dest_vld;
  logic [SCW-1:0]     r_stall_cnt;

  assign w_raw = r_dest_vld &&
                 ((w_rdata[SRCA_HI:SRCA_LO] == r_dest) ||
                  (w_rdata[SRCB_HI:SRCB_LO] == r_dest));
  assign w_stall_done = (r_stall_cnt == STALL_LAST);

  // Invalidation wins over capture so the last word of memory leaves no hazard.
  always_ff @(posedge clk) begin
    if (rst || w_start || w_to_fin) begin
      r_dest_vld <= 1'b0;
    end else if (w_xfer) begin
      r_dest_vld <= 1'b1;
      r_dest     <= r_instr[DEST_HI:DEST_LO];
    end
    if (rst || r_state != STALL) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + SCW'(1);
    end
  end
`else
  assign w_raw        = 1'b0;
  assign w_stall_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_ocupado <= 1'b0;
      r_hecho   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, FIN: begin
          if (inicio) begin
            r_state   <= LEER;
            r_pc      <= '0;
            r_ocupado <= 1'b1;
            r_hecho   <= 1'b0;
          end
        end
        LEER: begin
          r_instr <= w_rdata;
          if (w_halt) begin
            r_state   <= FIN;
            r_ocupado <= 1'b0;
            r_hecho   <= 1'b1;
          end else if (w_raw) begin
            r_state <= STALL;
          end else begin
            r_state <= EMITIR;
            r_valid <= 1'b1;
          end
        end
        STALL: begin
          if (w_stall_done) begin
            r_state <= EMITIR;
            r_valid <= 1'b1;
          end
        end
        EMITIR: begin
          if (instr_ready) begin
            r_valid <= 1'b0;
            if (w_last) begin
              r_state   <= FIN;
              r_ocupado <= 1'b0;
              r_hecho   <= 1'b1;
            end else begin
              r_pc    <= r_pc + AW'(1);
              r_state <= LEER;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign instruccion = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign ocupado     = r_ocupado;
  assign hecho       = r_hecho;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program-level reference model queues the
// expected transfers, an independent monitor checks every valid/ready handshake.
module tb_instr_fetch;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam logic [4:0] HALT_OP = 5'b11111;
`ifdef FETCH_RAW_STALL_EN
  localparam int STALL_N = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          carga_en;
  logic [AW-1:0] carga_dir;
  logic [19:0]   carga_dato;
  logic          inicio;
  logic [19:0]   instruccion;
  logic          instr_valid;
  logic          instr_ready;
  logic [AW-1:0] pc;
  logic          ocupado;
  logic          hecho;

  instr_fetch #(
    .DEPTH        (DEPTH),
    .AW           (AW),
    .OP_HALT      (5'b11111),
    .STALL_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .carga_en    (carga_en),
    .carga_dir   (carga_dir),
    .carga_dato  (carga_dato),
    .inicio      (inicio),
    .instruccion (instruccion),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .ocupado     (ocupado),
    .hecho       (hecho)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] instr;
    int          pc;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [19:0] model_mem [DEPTH];
  int          checks   = 0;
  int          failures = 0;
  int          n_xfer   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  // Monitor: pops one expectation per handshake, and checks that a stalled
  // word stays put while ready is low.
  initial begin
    exp_t        e;
    bit          holding;
    logic [19:0] hold_instr;
    logic [AW-1:0] hold_pc;
    holding = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding = 0;
      end else begin
        if (holding) begin
          checks++;
          if (!(instr_valid === 1'b1 && instruccion === hold_instr && pc === hold_pc)) begin
            failures++;
            $display("FAIL hold_stable got valid=%b instr=%h pc=%0d want valid=1 instr=%h pc=%0d",
                     instr_valid, instruccion, pc, hold_instr, hold_pc);
          end
        end
        holding = 0;
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
          checks++;
          n_xfer++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL xfer_unexpected got instr=%h pc=%0d want no transfer", instruccion, pc);
          end else begin
            e = exp_q.pop_front();
            if (instruccion !== e.instr || int'(pc) != e.pc || (e.cyc >= 0 && cyc != e.cyc)) begin
              failures++;
              $display("FAIL xfer got instr=%h pc=%0d cyc=%0d want instr=%h pc=%0d cyc=%0d",
                       instruccion, pc, cyc, e.instr, e.pc, e.cyc);
            end else begin
              $display("xfer instr=%h pc=%0d cyc=%0d", instruccion, pc, cyc);
            end
          end
        end else if (instr_valid === 1'b1) begin
          holding    = 1;
          hold_instr = instruccion;
          hold_pc    = pc;
        end
      end
    end
  end

  // Reference model: walk memory from 0, stop at HALT or the last word.
  // With ready held high each word costs 2 cycles, plus a bubble on a RAW hit.
  task automatic model_run(input int c0, input bit timed, output int done_cyc, output int end_pc);
    int          off;
    logic [19:0] w;
    exp_t        e;
`ifdef FETCH_RAW_STALL_EN
    bit          dv;
    logic [4:0]  dst;
    dv  = 0;
    dst = '0;
`endif
    off    = 2;
    end_pc = DEPTH - 1;
    for (int a = 0; a < DEPTH; a++) begin
      w = model_mem[a];
      if (w[19:15] == HALT_OP) begin
        done_cyc = c0 + off;
        end_pc   = a;
        return;
      end
`ifdef FETCH_RAW_STALL_EN
      if (dv && (w[14:10] == dst || w[9:5] == dst)) off += STALL_N;
      dst = w[4:0];
      dv  = 1;
`endif
      e.instr = w;
      e.pc    = a;
      e.cyc   = timed ? c0 + off : -1;
      exp_q.push_back(e);
      off += 2;
    end
    done_cyc = c0 + off - 1;
  endtask

  task automatic load(input int a, input logic [19:0] w);
    carga_en   = 1'b1;
    carga_dir  = 5'(a);
    carga_dato = w;
    model_mem[a] = w;
    @(posedge clk); #1;
    carga_en = 1'b0;
  endtask

  // mode 0: ready high, cycle-exact; 1: random ready; 2: 5-cycle backpressure;
  // 3: random ready plus carga_en/inicio pokes while busy.
  task automatic run_prog(input int mode, input string tag);
    int c0, done_cyc, end_pc, budget, bp;
    bp = 0;
    c0 = cyc;
    inicio = 1'b1;
    instr_ready = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    model_run(c0, mode == 0, done_cyc, end_pc);
    @(posedge clk); #1;
    inicio = 1'b0;
    budget = 0;
    while (hecho !== 1'b1 && budget < 1000) begin
      if (mode == 1 || mode == 3) instr_ready = 1'($urandom_range(0, 1));
      if (mode == 2) begin
        if (instr_valid === 1'b1 && bp < 5) bp++;
        instr_ready = (bp >= 5);
      end
      if (mode == 3) begin
        carga_en   = 1'($urandom_range(0, 1));
        carga_dir  = 5'($urandom);
        carga_dato = 20'($urandom);
        inicio     = ($urandom_range(0, 3) == 0);
      end
      @(posedge clk); #1;
      budget++;
    end
    carga_en    = 1'b0;
    inicio      = 1'b0;
    instr_ready = 1'b1;
    chk({tag, "_hecho"}, 32'(hecho), 32'd1);
    if (mode == 0) chk({tag, "_hecho_cycle"}, 32'(cyc), 32'(done_cyc));
    chk({tag, "_final_pc"}, 32'(pc), 32'(end_pc));
    chk({tag, "_all_issued"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_ocupado"}, 32'(ocupado), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [19:0] w;
    int budget;
    rst = 1'b1; carga_en = 1'b0; carga_dir = '0; carga_dato = '0;
    inicio = 1'b0; instr_ready = 1'b1;
    for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instruccion), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_hecho", 32'(hecho), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic program: two words then HALT at address 2.
    load(0, 20'b00000_01001_00110_01010);
    load(1, 20'b00010_00001_00100_01011);
    load(2, {HALT_OP, 15'h1234});
    run_prog(0, "basic");
    chk("basic_xfers", 32'(n_xfer), 32'd2);

    // End of memory: 32 non-HALT words.
    for (int a = 0; a < DEPTH; a++) load(a, {5'b00010, 15'($urandom)});
    run_prog(0, "eom");
    run_prog(2, "backpressure");
    run_prog(3, "ignored_inputs");
    run_prog(0, "after_ignored");

    // Reset while a word is waiting in EMITIR.
    instr_ready = 1'b0;
    inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    budget = 0;
    while (instr_valid !== 1'b1 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("midrst_valid_seen", 32'(instr_valid), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_ocupado", 32'(ocupado), 32'd0);
    chk("midrst_hecho", 32'(hecho), 32'd0);
    rst = 1'b0;
    instr_ready = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    run_prog(0, "after_rst");

    // RAW pair: second word reads the first word's destination.
    load(0, 20'b00100_01010_01011_01100);
    load(1, 20'b00011_01100_00101_01011);
    load(2, {HALT_OP, 15'h0});
    run_prog(0, "raw_pair");

    // Random programs with scattered HALTs.
    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < DEPTH; a++) begin
        w = 20'($urandom);
        if ($urandom_range(0, 7) == 0) w[19:15] = HALT_OP;
        else if (w[19:15] == HALT_OP) w[19:15] = 5'b00001;
        load(a, w);
      end
      run_prog(t % 4, $sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
